bp_me_nonsynth_lce_tr_replay: RTL
=================================

Name: bp_me_nonsynth_lce_tr_replay

Overview:
- Nonsynth trace-replay engine that drives a mock LCE with trace packets and checks its returned packets.
- Walks a synchronous trace ROM of SEND/RECV/FINISH entries.
- Issues SEND packets over ready/valid and compares each returned packet against RECV entries.
- Reports done, a sticky error flag and a mismatch count to the testbench.

Parameters:
- paddr_width_p, 39, physical address width of trace packet
- data_width_p, 64, data width of trace packet
- rom_addr_width_p, 10, trace ROM address width
- timeout_p, 4096, max idle cycles in RECV before watchdog fires (used only with optional feature)
- Derived: pkt_width = 4 + paddr_width_p + 1 + data_width_p (108 at defaults); entry_width = 2 + pkt_width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; reset is asynchronous and active-low
- start_i  in  1  pulse/level; begins replay from ROM address 0
- rom_addr_o  out  rom_addr_width_p  trace ROM read address
- rom_data_i  in  entry_width  ROM entry; valid one cycle after rom_addr_o
  - [entry_width-1 -: 2]: type, 00=SEND, 01=RECV, 10=FINISH, 11=reserved
  - remainder: packet {cmd[3:0], paddr, uncached, data}
- tr_pkt_o  out  pkt_width  packet to mock LCE
- tr_pkt_v_o  out  1  tr_pkt_o valid
- tr_pkt_ready_i  in  1  mock LCE accepts when tr_pkt_v_o & tr_pkt_ready_i
- tr_pkt_i  in  pkt_width  packet returned by mock LCE
- tr_pkt_v_i  in  1  tr_pkt_i valid
- tr_pkt_yumi_o  out  1  consumes tr_pkt_i this cycle
- done_o  out  1  replay finished
- error_o  out  1  sticky: mismatch, reserved type or timeout seen
- err_count_o  out  16  saturating mismatch count
- timeout_o  out  1  watchdog fired

Behaviour:
- Reset (asynchronous, reset_n_i=0): state=IDLE, rom_addr_o=0, all valid/yumi outputs 0, done_o=0, error_o=0, err_count_o=0, timeout_o=0, tr_pkt_o=0. Reset mid-operation aborts immediately; any in-flight handshake is dropped.
- States:
  - IDLE: wait for start_i=1; then go to FETCH with rom_addr_o=0.
  - FETCH: one cycle for ROM read latency; then go to DECODE.
  - DECODE: register rom_data_i.
    - SEND -> SEND state.
    - RECV -> RECV state.
    - FINISH -> DONE.
    - reserved -> set error_o, go to DONE.
  - SEND: tr_pkt_v_o=1 with tr_pkt_o held stable until tr_pkt_ready_i=1. On the handshake cycle: rom_addr_o+1, go to FETCH. tr_pkt_v_o must not drop before the handshake.
  - RECV: tr_pkt_yumi_o = tr_pkt_v_i (same cycle; yumi never asserted without v).
    - On consume, compare all fields (cmd, paddr, uncached, data) bitwise against the registered entry.
    - Mismatch: error_o<=1; err_count_o increments, saturating at 16'hFFFF.
    - Then rom_addr_o+1, go to FETCH.
  - DONE: done_o=1 and held; outputs frozen; start_i ignored until reset.
- Returned packets arriving outside RECV are not consumed (yumi=0) and stay pending.
- ROM wrap: if rom_addr_o reaches 2^rom_addr_width_p-1 and that entry is not FINISH, set error_o and go to DONE (no wrap to 0).
- Throughput: a SEND with ready held high takes 3 cycles (FETCH, DECODE, SEND). A RECV with v high takes 3 cycles.
- Comparison of data is full-width; trace author zero-fills unused bytes.

Optional Feature:
- Macro: BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN.
- Defined: a watchdog counter clears on RECV entry and counts each RECV cycle with tr_pkt_v_i=0. When it equals timeout_p: timeout_o<=1, error_o<=1, go to DONE.
- Undefined: no counter is built; timeout_o tied 0; RECV waits indefinitely.

Test Plan:
- ROM {SEND sb paddr=0x80 data=0xAB; RECV sb paddr=0x80 data=0xAB; FINISH}, ready=1, response returned 2 cycles after send -> done_o=1, error_o=0, err_count_o=0, exactly one tr_pkt_v_o handshake.
- Same trace, tr_pkt_ready_i low for 5 cycles -> tr_pkt_o stable and tr_pkt_v_o high for all 6 cycles; single handshake.
- RECV expects ld data=0x1122334455667788, mock returns 0x1122334455667789; run twice -> err_count_o=2, error_o=1, done_o=1.
- ROM entry type 11 at address 3 -> error_o=1, done_o=1, rom_addr_o=3, no further packets issued.
- With TIMEOUT_EN and timeout_p=16, RECV with no response -> timeout_o=1 after 16 idle cycles, done_o=1. Without the macro -> still in RECV after 1000 cycles, timeout_o=0.
- Assert reset_n_i=0 during a SEND stall -> tr_pkt_v_o=0 immediately. After release and start_i, replay restarts at rom_addr_o=0.

Source files
------------

// File: rtl/bp_me_nonsynth_lce_tr_replay.sv
// Trace-replay engine: walks a synchronous trace ROM, sends SEND packets to a mock LCE and checks returned packets against RECV entries.
// Optional watchdog on RECV waits: define BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN.
module bp_me_nonsynth_lce_tr_replay #(
    parameter int paddr_width_p    = 39,
    parameter int data_width_p     = 64,
    parameter int rom_addr_width_p = 10,
    parameter int timeout_p        = 4096,
    localparam int pkt_width_lp    = 4 + paddr_width_p + 1 + data_width_p,
    localparam int entry_width_lp  = 2 + pkt_width_lp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [entry_width_lp-1:0]   rom_data_i,
    output logic [pkt_width_lp-1:0]     tr_pkt_o,
    output logic                        tr_pkt_v_o,
    input  logic                        tr_pkt_ready_i,
    input  logic [pkt_width_lp-1:0]     tr_pkt_i,
    input  logic                        tr_pkt_v_i,
    output logic                        tr_pkt_yumi_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [15:0]                 err_count_o,
    output logic                        timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_SEND, ST_RECV, ST_DONE
    } state_e;

    localparam logic [1:0] TYPE_SEND   = 2'b00;
    localparam logic [1:0] TYPE_RECV   = 2'b01;
    localparam logic [1:0] TYPE_FINISH = 2'b10;

    // Handshakes: outgoing packet transfers on a cycle with tr_pkt_v_o & tr_pkt_ready_i,
    // and once raised tr_pkt_v_o/tr_pkt_o hold until that cycle; incoming packet is consumed
    // on a cycle with tr_pkt_yumi_o, which is only ever raised alongside tr_pkt_v_i.
    state_e                        state_q, state_d;
    logic [rom_addr_width_p-1:0]   rom_addr_q, rom_addr_d;
    logic [pkt_width_lp-1:0]       pkt_q, pkt_d;
    logic                          error_q, error_d;
    logic [15:0]                   err_count_q, err_count_d;
    logic [1:0]                    entry_type;
    logic [pkt_width_lp-1:0]       entry_pkt;
    logic                          last_addr;

    assign entry_type = rom_data_i[entry_width_lp-1 -: 2];
    assign entry_pkt  = rom_data_i[pkt_width_lp-1:0];
    assign last_addr  = (rom_addr_q == {rom_addr_width_p{1'b1}});

`ifdef BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN
    localparam int wd_width_lp = $clog2(timeout_p + 1);
    logic [wd_width_lp-1:0] wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    assign timeout_o = timeout_q;
`else
    // Without the watchdog RECV waits forever; timeout_p only matters when it is built.
    assign timeout_o = (timeout_p < 0);
`endif

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        pkt_d         = pkt_q;
        error_d       = error_q;
        err_count_d   = err_count_q;
        tr_pkt_yumi_o = 1'b0;
`ifdef BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN
        wd_d          = wd_q;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rom_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                // The last ROM slot must terminate the trace; the address never wraps.
                if (last_addr && (entry_type != TYPE_FINISH)) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    case (entry_type)
                        TYPE_SEND: begin
                            pkt_d   = entry_pkt;
                            state_d = ST_SEND;
                        end
                        TYPE_RECV: begin
                            pkt_d   = entry_pkt;
                            state_d = ST_RECV;
`ifdef BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN
                            wd_d    = '0;
`endif
                        end
                        TYPE_FINISH: state_d = ST_DONE;
                        default: begin
                            error_d = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_SEND: begin
                if (tr_pkt_ready_i) begin
                    rom_addr_d = rom_addr_q + rom_addr_width_p'(1);
                    state_d    = ST_FETCH;
                end
            end
            ST_RECV: begin
                if (tr_pkt_v_i) begin
                    tr_pkt_yumi_o = 1'b1;
                    if (tr_pkt_i != pkt_q) begin
                        error_d = 1'b1;
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                    end
                    rom_addr_d = rom_addr_q + rom_addr_width_p'(1);
                    state_d    = ST_FETCH;
                end
`ifdef BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN
                else if (wd_q == wd_width_lp'(timeout_p - 1)) begin
                    wd_d      = wd_width_lp'(timeout_p);
                    timeout_d = 1'b1;
                    error_d   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wd_d = wd_q + wd_width_lp'(1);
                end
`endif
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            pkt_q       <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
`ifdef BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            pkt_q       <= pkt_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
`ifdef BP_ME_NONSYNTH_TR_REPLAY_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign tr_pkt_o    = pkt_q;
    assign tr_pkt_v_o  = (state_q == ST_SEND);
    assign done_o      = (state_q == ST_DONE);
    assign error_o     = error_q;
    assign err_count_o = err_count_q;

endmodule
